demux8_scan_ctrl: RTL and testbench
===================================

Name: demux8_scan_ctrl

Overview:
- Sequencer for the 1-to-8 demultiplexer datapath.
- Steps a 3-bit select through outputs 0..7 at a programmable tick rate.
- Drives the active-low demux enable.
- Produces a registered one-hot, data-gated output word for the board LEDs (LEDR).
- Supports continuous scan or a single sweep, with start/stop control.

Parameters:
- DIV, 25000000, CLOCK_50 cycles per select step; legal range >= 2.
- DIV_W, 25, prescaler counter width; must hold DIV-1.
- OUT_N, 8, number of demux outputs; fixed at 8.
- SEL_W, 3, select width; log2(OUT_N).

Ports:
- CLOCK_50  in  1  system clock; all state changes on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- start  in  1  level; begins a scan from IDLE.
- stop  in  1  level; aborts a scan.
- mode  in  1  0 = continuous scan, 1 = single sweep 0..7.
- data  in  1  demux data input.
- sel  out  SEL_W  current select to the demux.
- en_n  out  1  active-low demux enable; 0 only while scanning.
- LEDR  out  OUT_N  registered demux output.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at the end of a single sweep.

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - state=IDLE, prescaler=0, sel=0, en_n=1, LEDR=0, busy=0, done=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - en_n=1, LEDR=0, prescaler held at 0.
  - start=1 and stop=0 -> RUN next cycle, with sel=0 and prescaler=0.
- RUN:
  - en_n=0, busy=1.
  - Prescaler counts 0..DIV-1 and wraps; tick is asserted when prescaler==DIV-1.
  - On a tick, sel increments modulo 8 (7 wraps to 0).
  - mode is sampled on every tick. Tick with sel==7 and mode=1 -> DONE; sel goes to 0.
  - stop=1 -> IDLE on the next edge; sel=0, prescaler=0. stop has priority over a tick in the same cycle.
- DONE:
  - One cycle only: done=1, en_n=1, busy=0.
  - Then IDLE unconditionally; start is ignored in DONE.
- Start/stop interaction:
  - start and stop both high in IDLE -> stay in IDLE.
  - start is ignored in RUN.
- LEDR:
  - Registered; one-cycle latency.
  - LEDR[i] <= (state==RUN) & (sel==i) & data, evaluated each cycle.
  - At most one bit is set. LEDR is 0 the cycle after leaving RUN.
- Timing:
  - sel is stable for exactly DIV cycles per step.
  - A full single sweep lasts 8*DIV cycles in RUN, plus one DONE cycle.
- Reset asserted mid-scan: immediate return to reset values, no done pulse.

Optional Feature:
- Macro: SCAN_DIR_EN.
- Defined:
  - Adds input port dir (1 bit).
  - dir=0: count up, as above.
  - dir=1: sel decrements modulo 8, starting from 7.
  - Single sweep ends on the tick at sel==0.
  - dir is sampled only on the IDLE->RUN transition; changes during RUN are ignored.
- Not defined: no dir port; up-count only.

Decomposition:
- Package demux_ctrl_pkg holds:
  - state typedef (IDLE, RUN, DONE);
  - OUT_N = 8, SEL_W = 3;
  - SEL_FIRST = 0, SEL_LAST = 7.
- Sub-module tick_gen: parameterised DIV/DIV_W prescaler.
  - Inputs: CLOCK_50, RESET_N, clr (synchronous clear), en.
  - Output: tick.
- The FSM, select counter and LEDR register live in demux8_scan_ctrl.

Test Plan:
- Reset value check (DIV=4): assert RESET_N=0 mid-RUN at sel=5 -> same cycle: sel=0, en_n=1, LEDR=0, busy=0; no done pulse.
- Continuous scan (DIV=4, mode=0, data=1, start pulse):
  - LEDR sequence 0x01,0x02,...,0x80,0x01.
  - Each value holds 4 cycles.
  - LEDR lags sel by one cycle.
- Single sweep (DIV=4, mode=1): start -> done pulses once exactly 32 cycles after entry to RUN; then IDLE, LEDR=0, en_n=1.
- Data gating (DIV=4): data=0 during sel=3 -> LEDR=0x00 for that step; data=1 at sel=4 -> LEDR=0x10.
- Stop priority: stop asserted on the tick cycle at sel=6 -> next cycle IDLE, sel=0, sel never shows 7. Also start=stop=1 in IDLE -> stays IDLE.
- SCAN_DIR_EN build, dir=1, mode=1, DIV=4: sel sequence 7,6,...,0, then done pulse. A dir toggle mid-RUN has no effect.

Source files
------------

// File: rtl/demux_ctrl_pkg.sv
// Shared definitions for the 1-to-8 demux scan controller.
//   state_t    : sequencer states (IDLE, RUN, DONE)
//   OUT_N      : number of demux outputs (fixed at 8)
//   SEL_W      : select width, log2(OUT_N)
//   SEL_FIRST  : first select of an up-count sweep
//   SEL_LAST   : last select of an up-count sweep
//   onehot()   : select value to one-hot LED word
package demux_ctrl_pkg;

  localparam int OUT_N = 8;
  localparam int SEL_W = 3;

  localparam logic [SEL_W-1:0] SEL_FIRST = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(OUT_N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [OUT_N-1:0] onehot(input logic [SEL_W-1:0] s);
    logic [OUT_N-1:0] r;
    r    = '0;
    r[s] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing one tick every DIV cycles of CLOCK_50.
//   CLOCK_50 : system clock
//   RESET_N  : asynchronous active-low reset
//   clr      : synchronous clear of the count (wins over en)
//   en       : count enable; the count is held at 0 while low
//   tick     : high during the last cycle (count == DIV-1) of each period
// DIV must be >= 2 and DIV_W wide enough to hold DIV-1.
module tick_gen #(
  parameter int DIV   = 25000000,
  parameter int DIV_W = 25
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [DIV_W-1:0] CNT_MAX = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] cnt_q;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q <= '0;
    end else if (clr || !en) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DIV_W'(1);
    end
  end

  // A cleared cycle never ticks, so a stop in the same cycle suppresses the step.
  assign tick = en & ~clr & (cnt_q == CNT_MAX);

endmodule

// File: rtl/demux8_scan_ctrl.sv
// Scan sequencer for the 1-to-8 demultiplexer datapath.
// Steps the demux select through 0..7 (one step per DIV clocks), drives the
// active-low demux enable and a registered, data-gated one-hot LED word.
//   CLOCK_50 : system clock
//   RESET_N  : asynchronous active-low reset
//   start    : level; begins a scan from IDLE (ignored if stop is high)
//   stop     : level; aborts a scan, priority over a step
//   mode     : 0 = continuous scan, 1 = single sweep (sampled on each step)
//   data     : demux data input, gates LEDR
//   dir      : (SCAN_DIR_EN builds only) 1 = count down from 7, sampled at start
//   sel      : current demux select
//   en_n     : active-low demux enable, low only in RUN
//   LEDR     : registered one-hot demux output, one cycle behind sel
//   busy     : high in RUN
//   done     : one-cycle pulse at the end of a single sweep
// Optional feature macro: SCAN_DIR_EN (adds the dir port and down-counting).
module demux8_scan_ctrl
  import demux_ctrl_pkg::*;
#(
  parameter int DIV   = 25000000,
  parameter int DIV_W = 25
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             data,
`ifdef SCAN_DIR_EN
  input  logic             dir,
`endif
  output logic [SEL_W-1:0] sel,
  output logic             en_n,
  output logic [OUT_N-1:0] LEDR,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             down_q, down_d;
  logic [SEL_W-1:0] sel_end;
  logic             run;
  logic             tick;
  logic [OUT_N-1:0] ledr_p0;

  assign run = (state_q == RUN);

  tick_gen #(
    .DIV   (DIV),
    .DIV_W (DIV_W)
  ) u_tick_gen (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .clr      (~run | stop),
    .en       (run),
    .tick     (tick)
  );

  // The sweep ends on the step taken from the last select in the scan direction.
  assign sel_end = down_q ? SEL_FIRST : SEL_LAST;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      sel_q   <= SEL_FIRST;
      down_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      down_q  <= down_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    down_d  = down_q;
    case (state_q)
      IDLE: begin
        sel_d = SEL_FIRST;
        if (start && !stop) begin
          state_d = RUN;
`ifdef SCAN_DIR_EN
          down_d  = dir;
          sel_d   = dir ? SEL_LAST : SEL_FIRST;
`else
          down_d  = 1'b0;
`endif
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          sel_d   = SEL_FIRST;
        end else if (tick) begin
          if (mode && (sel_q == sel_end)) begin
            state_d = DONE;
            sel_d   = SEL_FIRST;
          end else if (down_q) begin
            sel_d = sel_q - SEL_W'(1);
          end else begin
            sel_d = sel_q + SEL_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        sel_d   = SEL_FIRST;
      end
      default: begin
        state_d = IDLE;
        sel_d   = SEL_FIRST;
      end
    endcase
  end

  // ---- stage p0: LED register, one cycle behind state/sel ----
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      ledr_p0 <= '0;
    end else begin
      ledr_p0 <= (run && data) ? onehot(sel_q) : '0;
    end
  end

  assign sel  = sel_q;
  assign en_n = ~run;
  assign busy = run;
  assign done = (state_q == DONE);
  assign LEDR = ledr_p0;

endmodule

// File: tb/tb_demux8_scan_ctrl.sv
// Self-checking bench for demux8_scan_ctrl (DIV=4): directed scenarios plus a
// randomized phase whose expected outputs come from a cycle-count model and
// are checked by a separate scoreboard monitor.
module tb_demux8_scan_ctrl;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       mode = 1'b0;
  logic       data = 1'b0;
  logic       dir = 1'b0;
  logic [2:0] sel;
  logic       en_n;
  logic [7:0] ledr;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail = 0;

  demux8_scan_ctrl #(
    .DIV   (DIV),
    .DIV_W (4)
  ) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .data     (data),
`ifdef SCAN_DIR_EN
    .dir      (dir),
`endif
    .sel      (sel),
    .en_n     (en_n),
    .LEDR     (ledr),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [2:0] sel;
    logic       en_n;
    logic [7:0] ledr;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      check("sb_sel", 32'(sel), 32'(mon_e.sel));
      check("sb_en_n", 32'(en_n), 32'(mon_e.en_n));
      check("sb_ledr", 32'(ledr), 32'(mon_e.ledr));
      check("sb_busy", 32'(busy), 32'(mon_e.busy));
      check("sb_done", 32'(done), 32'(mon_e.done));
    end
  end

  // ---------------- reference model ----------------
  // Position in a scan is derived from the number of cycles spent in RUN.
  int   m_state = 0;   // 0 idle, 1 run, 2 done
  int   m_cnt = 0;     // cycles since entering RUN
  bit   m_down = 0;

  function automatic int m_sel();
    int step;
    if (m_state != 1) return 0;
    step = (m_cnt / DIV) % 8;
    return m_down ? 7 - step : step;
  endfunction

  // Advance the model across one rising edge using the current inputs.
  task automatic model_step();
    exp_t e;
    logic [7:0] led_n;
    led_n = (m_state == 1 && data) ? 8'(1 << m_sel()) : 8'h00;
    case (m_state)
      0: if (start && !stop) begin
           m_state = 1;
           m_cnt = 0;
`ifdef SCAN_DIR_EN
           m_down = dir;
`else
           m_down = 0;
`endif
         end
      1: if (stop) m_state = 0;
         else if ((m_cnt % DIV) == DIV - 1 && mode && m_sel() == (m_down ? 0 : 7)) m_state = 2;
         else m_cnt++;
      default: m_state = 0;
    endcase
    e.sel  = 3'(m_sel());
    e.en_n = (m_state != 1);
    e.ledr = led_n;
    e.busy = (m_state == 1);
    e.done = (m_state == 2);
    q.push_back(e);
  endtask

  // ---------------- directed helpers ----------------
  task automatic start_run(input logic m);
    @(negedge clk);
    mode = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic stop_run();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic wait_sel(input logic [2:0] v, input string name);
    int n = 0;
    while (sel !== v && n < 64) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(sel), 32'(v));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit seen7;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_sel", 32'(sel), 0);
    check("rst_en_n", 32'(en_n), 1);
    check("rst_ledr", 32'(ledr), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    rst_n = 1'b1;

    // Continuous scan: each LED value holds DIV cycles, one cycle behind sel
    data = 1'b1;
    start_run(1'b0);
    for (int i = 0; i < 36; i++) begin
      if (i > 0) @(negedge clk);
      check("cont_sel", 32'(sel), 32'((i / DIV) % 8));
      check("cont_ledr", 32'(ledr), (i == 0) ? 32'h0 : 32'(1 << (((i - 1) / DIV) % 8)));
    end
    stop_run();
    check("cont_stop_busy", 32'(busy), 0);

    // Single sweep: done after 8*DIV cycles of RUN
    start_run(1'b1);
    k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("sweep_len", 32'(k), 32'(8 * DIV));
    check("sweep_done_en_n", 32'(en_n), 1);
    check("sweep_done_busy", 32'(busy), 0);
    @(negedge clk);
    check("sweep_after_done", 32'(done), 0);
    check("sweep_after_ledr", 32'(ledr), 0);
    check("sweep_after_en_n", 32'(en_n), 1);
    check("sweep_after_sel", 32'(sel), 0);

    // Data gating
    data = 1'b1;
    start_run(1'b0);
    wait_sel(3'd3, "gate_wait3");
    data = 1'b0;
    @(negedge clk);
    check("gate_ledr_s3", 32'(ledr), 0);
    wait_sel(3'd4, "gate_wait4");
    check("gate_ledr_s3_last", 32'(ledr), 0);
    data = 1'b1;
    @(negedge clk);
    check("gate_ledr_s4", 32'(ledr), 32'h10);
    stop_run();

    // Stop on the tick cycle at sel=6 beats the step
    start_run(1'b0);
    wait_sel(3'd6, "stop_wait6");
    repeat (DIV - 1) @(negedge clk);
    stop_run();
    check("stop_sel", 32'(sel), 0);
    check("stop_busy", 32'(busy), 0);
    check("stop_en_n", 32'(en_n), 1);
    seen7 = 0;
    repeat (6) begin
      @(negedge clk);
      if (sel == 3'd7) seen7 = 1;
    end
    check("stop_no_sel7", 32'(seen7), 0);

    // start and stop together in IDLE
    start = 1'b1;
    stop = 1'b1;
    repeat (3) @(negedge clk);
    check("startstop_busy", 32'(busy), 0);
    check("startstop_en_n", 32'(en_n), 1);
    start = 1'b0;
    stop = 1'b0;

`ifdef SCAN_DIR_EN
    // Down-count single sweep; dir changes mid-run are ignored
    dir = 1'b1;
    start_run(1'b1);
    for (int i = 0; i < 8 * DIV; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 10) dir = 1'b0;
      check("dir_sel", 32'(sel), 32'(7 - i / DIV));
    end
    @(negedge clk);
    check("dir_done", 32'(done), 1);
    @(negedge clk);
    check("dir_after_done", 32'(done), 0);
`endif

    // Randomized phase against the model
    m_state = 0;
    mode = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      #2;
      start = ($urandom % 4) == 0;
      stop = ($urandom % 64) == 0;
      if (($urandom % 50) == 0) mode = ~mode;
      data = $urandom % 2;
      dir = $urandom % 2;
      model_step();
    end
    @(negedge clk);
    #2;
    start = 1'b0;
    stop = 1'b1;
    repeat (2) @(negedge clk);
    stop = 1'b0;
    check("sb_drained", 32'(q.size()), 0);

    // Asynchronous reset in the middle of a scan
    dir = 1'b0;
    data = 1'b1;
    start_run(1'b0);
    wait_sel(3'd5, "rstmid_wait5");
    #1;
    rst_n = 1'b0;
    #1;
    check("rstmid_sel", 32'(sel), 0);
    check("rstmid_en_n", 32'(en_n), 1);
    check("rstmid_ledr", 32'(ledr), 0);
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_done", 32'(done), 0);
    k = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) k++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done) k++;
    end
    check("rstmid_no_done", 32'(k), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
